uart_bram_ctrl: RTL and testbench

//  Initiator side of the block-RAM port: parses command bytes from the UART receiver, drives the
//  RAM write/read strobes, and returns read data to the UART transmitter. Sits between uart_rx/

---
 rtl/uart_bram_if.sv | 29 ++
 rtl/uart_bram_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_bram_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_bram_if.sv
// Signal bundle between the UART command controller and its neighbours:
// the receiver stream, the transmitter stream and the block-RAM port.
interface uart_bram_if #(
    parameter int unsigned RAM_ADDR_BITS = 13
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     ram_write_enable;
    logic                     ram_read_enable;
    logic [RAM_ADDR_BITS-1:0] ram_address;
    logic [7:0]               ram_write_data;
    logic [7:0]               ram_read_data;
    logic                     busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, ram_read_data,
        output tx_data, tx_valid, ram_write_enable, ram_read_enable, ram_address,
               ram_write_data, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, ram_read_data,
        input  tx_data, tx_valid, ram_write_enable, ram_read_enable, ram_address,
               ram_write_data, busy
    );
endinterface

// File: rtl/uart_bram_ctrl.sv
// UART command parser driving a block-RAM port: burst writes from received bytes,
// burst reads streamed back to the transmitter, with an inter-byte timeout on commands.
module uart_bram_ctrl #(
    parameter int unsigned RAM_ADDR_BITS  = 13,
    parameter int unsigned TIMEOUT_CYCLES = 2_700_000
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_bram_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StAddrLo, StLen, StWrData, StRdReq, StRdWait, StRdSend
    } state_e;

    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [RAM_ADDR_BITS-1:0] AddrOne = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic                     rw_q, rw_d;
    logic [6:0]               addr_hi_q, addr_hi_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [31:0]              tmo_q, tmo_d;
    logic                     wr_pend_q, wr_pend_d;
    logic [7:0]               wr_data_q, wr_data_d;
    logic                     done_q, done_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [14:0]              full_addr;
    logic                     timed;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_hi_d  = addr_hi_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        wr_pend_d  = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        full_addr  = {addr_hi_q, bus.rx_data};
        timed      = (state_q == StAddrLo) || (state_q == StLen) ||
                     ((state_q == StWrData) && !done_q);

        if (timed && !bus.rx_valid) tmo_d = tmo_q + 32'd1;
        // The write strobe uses the current address; advance it once the write issues.
        if (wr_pend_q) addr_d = addr_q + AddrOne;

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    rw_d      = bus.rx_data[7];
                    addr_hi_d = bus.rx_data[6:0];
                    state_d   = StAddrLo;
                end
            end
            StAddrLo: begin
                if (bus.rx_valid) begin
                    addr_d  = full_addr[RAM_ADDR_BITS-1:0];
                    state_d = StLen;
                end else if (tmo_q >= TmoLast) begin
                    state_d = StIdle;
                end
            end
            StLen: begin
                if (bus.rx_valid) begin
                    cnt_d   = bus.rx_data;
                    done_d  = 1'b0;
                    state_d = rw_q ? StRdReq : StWrData;
                end else if (tmo_q >= TmoLast) begin
                    state_d = StIdle;
                end
            end
            StWrData: begin
                if (done_q) begin
                    // Final write issues this cycle; a coinciding byte starts the next frame.
                    done_d  = 1'b0;
                    state_d = StIdle;
                    if (bus.rx_valid) begin
                        rw_d      = bus.rx_data[7];
                        addr_hi_d = bus.rx_data[6:0];
                        state_d   = StAddrLo;
                    end
                end else if (bus.rx_valid) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = bus.rx_data;
                    if (cnt_q == 8'd0) done_d = 1'b1;
                    else               cnt_d  = cnt_q - 8'd1;
                end else if (tmo_q >= TmoLast) begin
                    state_d = StIdle;
                end
            end
            StRdReq: state_d = StRdWait;
            StRdWait: begin
                tx_data_d  = bus.ram_read_data;
                tx_valid_d = 1'b1;
                state_d    = StRdSend;
            end
            StRdSend: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_q + AddrOne;
                        state_d = StRdReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rw_q       <= 1'b0;
            addr_hi_q  <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_hi_q  <= addr_hi_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            wr_pend_q  <= wr_pend_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign bus.tx_data          = tx_data_q;
    assign bus.tx_valid         = tx_valid_q;
    assign bus.ram_write_enable = wr_pend_q;
    assign bus.ram_read_enable  = (state_q == StRdReq);
    assign bus.ram_address      = addr_q;
    assign bus.ram_write_data   = wr_data_q;
    assign bus.busy             = (state_q != StIdle);
endmodule

// File: tb/tb_uart_bram_ctrl.sv
// Directed bench for uart_bram_ctrl: small RAM model, strobe/tx loggers, fixed expected values.
module tb_uart_bram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_bram_if #(.RAM_ADDR_BITS(13)) bus ();

    uart_bram_ctrl #(.RAM_ADDR_BITS(13), .TIMEOUT_CYCLES(200)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:8191];
    logic [20:0] wr_log [$];
    logic [7:0]  tx_log [$];
    int          rd_cnt = 0;
    int          viol = 0;

    always @(posedge clk) begin
        if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_write_data;
        if (bus.ram_read_enable)  bus.ram_read_data <= mem[bus.ram_address];
    end

    always @(posedge clk) begin
        if (bus.ram_write_enable) wr_log.push_back({bus.ram_address, bus.ram_write_data});
        if (bus.ram_read_enable) rd_cnt++;
        if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
        if (bus.ram_write_enable && bus.ram_read_enable) viol++;
        if ((bus.ram_write_enable || bus.ram_read_enable) && !bus.busy) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input int n_tx, input int limit, input string tag);
        int i;
        for (i = 0; i < limit && !(tx_log.size() >= n_tx && !bus.busy); i++) @(negedge clk);
        check(tag, 32'(i < limit), 32'd1);
    endtask

    logic [7:0] d0;
    int         bad;

    initial begin
        bus.rx_data       = 8'h00;
        bus.rx_valid      = 1'b0;
        bus.tx_ready      = 1'b1;
        bus.ram_read_data = 8'h00;

        // 1. Reset held with rx activity
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'h81;
            @(negedge clk); bus.rx_valid = 1'b0;
        end
        check("reset_outputs", 32'({bus.tx_data, bus.tx_valid, bus.ram_write_enable,
              bus.ram_read_enable, bus.ram_address, bus.ram_write_data, bus.busy}), 32'd0);
        check("reset_strobes", 32'(wr_log.size() + rd_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2. Write 3 bytes at 0x0010
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_done(0, 50, "wr3_idle");
        check("wr3_count", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) begin
            check("wr3_0", 32'(wr_log[0]), {11'd0, 13'h0010, 8'hAA});
            check("wr3_1", 32'(wr_log[1]), {11'd0, 13'h0011, 8'hBB});
            check("wr3_2", 32'(wr_log[2]), {11'd0, 13'h0012, 8'hCC});
        end

        // 3. Read back with backpressure on the second byte
        tx_log.delete(); rd_cnt = 0;
        send_byte(8'h80); send_byte(8'h10); send_byte(8'h02);
        for (int i = 0; i < 100 && tx_log.size() < 1; i++) @(negedge clk);
        bus.tx_ready = 1'b0;
        repeat (5) @(negedge clk);
        d0 = bus.tx_data;
        check("rd_hold_valid", 32'(bus.tx_valid), 32'd1);
        check("rd_hold_data", 32'(d0), 32'hBB);
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data != d0) bad++;
        end
        check("rd_hold_stable", 32'(bad), 32'd0);
        bus.tx_ready = 1'b1;
        wait_done(3, 100, "rd3_done");
        check("rd3_count", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() == 3) begin
            check("rd3_0", 32'(tx_log[0]), 32'hAA);
            check("rd3_1", 32'(tx_log[1]), 32'hBB);
            check("rd3_2", 32'(tx_log[2]), 32'hCC);
        end
        check("rd3_strobes", 32'(rd_cnt), 32'd3);

        // 4. Address wrap within a burst
        wr_log.delete(); tx_log.delete();
        send_byte(8'h1F); send_byte(8'hFF); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        wait_done(0, 50, "wrap_wr_idle");
        check("wrap_wr_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("wrap_wr_0", 32'(wr_log[0]), {11'd0, 13'h1FFF, 8'h11});
            check("wrap_wr_1", 32'(wr_log[1]), {11'd0, 13'h0000, 8'h22});
        end
        send_byte(8'h9F); send_byte(8'hFF); send_byte(8'h01);
        wait_done(2, 100, "wrap_rd_done");
        check("wrap_rd", 32'({tx_log.size() == 2 ? tx_log[0] : 8'h00,
                              tx_log.size() == 2 ? tx_log[1] : 8'h00}), 32'h1122);

        // 5. Timeout after two header bytes
        wr_log.delete();
        send_byte(8'h00); send_byte(8'h20);
        repeat (150) @(negedge clk);
        check("tmo_still_busy", 32'(bus.busy), 32'd1);
        repeat (100) @(negedge clk);
        check("tmo_idle", 32'(bus.busy), 32'd0);
        check("tmo_no_writes", 32'(wr_log.size()), 32'd0);
        send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h55);
        wait_done(0, 50, "tmo_next_idle");
        check("tmo_next_write", 32'(wr_log.size() == 1 ? wr_log[0] : 21'd0),
              {11'd0, 13'h0030, 8'h55});

        // 6. Fill 256 bytes at 0x0100, read them back with stray rx pulses
        wr_log.delete(); tx_log.delete(); rd_cnt = 0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A);
        wait_done(0, 50, "max_wr_idle");
        check("max_wr_count", 32'(wr_log.size()), 32'd256);
        send_byte(8'h81); send_byte(8'h00); send_byte(8'hFF);
        for (int i = 0; i < 3000 && !(tx_log.size() >= 256 && !bus.busy); i++) begin
            @(negedge clk);
            bus.rx_data  = 8'h00;
            bus.rx_valid = (i % 37 == 5);
        end
        bus.rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("max_rd_count", 32'(tx_log.size()), 32'd256);
        check("max_rd_strobes", 32'(rd_cnt), 32'd256);
        check("max_stray_idle", 32'(bus.busy), 32'd0);
        bad = 0;
        for (int i = 0; i < tx_log.size() && i < 256; i++)
            if (tx_log[i] != (8'(i) ^ 8'h5A)) bad++;
        check("max_rd_data", 32'(bad), 32'd0);

        // Reset in the middle of the next read burst
        rd_cnt = 0;
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h05);
        for (int i = 0; i < 100 && rd_cnt < 2; i++) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({bus.tx_data, bus.tx_valid, bus.ram_write_enable,
              bus.ram_read_enable, bus.ram_address, bus.ram_write_data, bus.busy}), 32'd0);
        check("strobe_rules", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
